subleq_core: RTL and testbench
==============================

Name: subleq_core

Overview:
- Single-cycle-per-access SUBLEQ sequencer; the block directly upstream of the unified word memory.
- Drives the memory's load/store/addr/mem_in lines and consumes its combinational mem_out.
- Executes `mem[B] = mem[B] - mem[A]; if result <= 0 (signed) then pc = C else pc = pc + 3`.
- One memory access per cycle, 6 cycles per instruction, plus run/halt control and a retired-instruction counter.

Parameters:
- WORD_SIZE, 8: data and address width; memory depth is 2^WORD_SIZE words.
- RESET_PC, 0: pc value after reset.
- HALT_ADDR, 2^WORD_SIZE-1 (all ones): a taken branch to this address halts the core.
- CNT_WIDTH, 16: width of the retired-instruction counter.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- areset, input, 1: reset, synchronous, active-high.
- run, input, 1: permits a new instruction fetch.
- load, output, 1: memory read enable.
- store, output, 1: memory write enable.
- addr, output, WORD_SIZE: memory address.
- mem_wdata, output, WORD_SIZE: write data, connects to memory mem_in.
- mem_rdata, input, WORD_SIZE: read data, connects to memory mem_out; combinational from addr/load.
- pc, output, WORD_SIZE: current program counter.
- halted, output, 1: core halted.
- retired, output, CNT_WIDTH: count of completed instructions.

Behaviour:
- Moore outputs. load, store, addr and mem_wdata are decoded from registered state only, never from mem_rdata.
- States and per-state actions:
  - F_A: addr=pc, load=run. Latches ra<=mem_rdata. Goes to F_B if run=1, else stays.
  - F_B: addr=pc+1, load=1. Latches rb. Goes to F_C.
  - F_C: addr=pc+2, load=1. Latches rc. Goes to R_A.
  - R_A: addr=ra, load=1. Latches va. Goes to R_B.
  - R_B: addr=rb, load=1. Latches vb. Goes to WR.
  - WR: addr=rb, store=1, mem_wdata=vb-va. Updates pc, increments retired, goes to F_A; goes to HALT if the branch is taken and rc==HALT_ADDR.
  - HALT: load=0, store=0, addr=pc. Stays until reset; run is ignored.
- load and store are never both 1 in the same cycle. store is high for exactly one cycle per instruction.
- Arithmetic:
  - Subtraction is modulo 2^WORD_SIZE.
  - Branch is taken when the result MSB=1 or the result is all zero.
  - Next pc = taken ? rc : pc+3, modulo 2^WORD_SIZE.
  - Operand addresses pc+1 and pc+2 wrap modulo 2^WORD_SIZE.
- Self-modifying code: WR's store lands at the clock edge ending WR, so the next F_A sees the updated memory. An instruction that overwrites its own operand words takes effect on its next execution.
- Halting:
  - On entry to HALT, pc=HALT_ADDR, halted=1, and retired includes the halting instruction.
  - A non-taken result never halts, even when pc+3 wraps onto HALT_ADDR.
- retired wraps to 0 after all ones.
- run is sampled only in F_A. Deasserting run mid-instruction completes the current instruction and then stalls in F_A with load=0.
- Reset, including mid-instruction:
  - While areset=1 at a rising edge, the next state is state=F_A, pc=RESET_PC, ra/rb/rc/va/vb=0, retired=0, halted=0.
  - A store pending in WR at that edge is suppressed: store is forced to 0 while areset=1.
  - Outputs after reset: load=run, store=0, addr=RESET_PC, mem_wdata=0.

Test Plan:
- Basic subtract: W=8, mem[0..2]={10,11,20}, mem[0x10]=3, mem[0x11]=5, run=1 -> store in cycle 6 with addr=0x11, mem_wdata=0x02; then pc=0x03, retired=1.
- Branch on zero and on negative:
  - mem[0x10]=5, mem[0x11]=5 -> mem[0x11]=0x00, pc=0x20.
  - mem[0x10]=5, mem[0x11]=3 -> mem[0x11]=0xFE, pc=0x20.
- Halt: C=0xFF and the result is taken -> halted=1 after WR, pc=0xFF, retired=1. Then 20 further cycles with run=1 show load=0 and store=0.
- Address wrap: RESET_PC=0xFE -> operands fetched from 0xFE, 0xFF, 0x00; a non-taken result gives pc=0x01 and no halt.
- Run gating: run=0 out of reset -> load=0 and state held for 10 cycles. Pulse run=1 for one cycle, then run=0 -> exactly one instruction retires, then the core stalls in F_A.
- Reset mid-instruction: assert areset in the WR cycle -> store=0 that cycle, mem[0x11] unchanged, then pc=RESET_PC and retired=0. Execution restarts cleanly.

Source files
------------

// File: rtl/subleq_core.sv
// subleq_core: single-access-per-cycle SUBLEQ sequencer sitting in front of a
// unified word memory with a combinational read port.
//
// Each instruction takes six cycles (fetch A, B, C, read mem[A], read mem[B],
// write mem[B]) and performs
//   mem[B] = mem[B] - mem[A]; if (result <= 0) pc = C else pc = pc + 3
// A taken branch to HALT_ADDR stops the core until reset.
//
// Ports:
//   clk        rising-edge clock
//   areset     synchronous active-high reset
//   run        permits a new instruction fetch (sampled only in F_A)
//   load       memory read enable
//   store      memory write enable (one cycle per instruction)
//   addr       memory address
//   mem_wdata  write data to memory
//   mem_rdata  read data from memory (combinational from addr/load)
//   pc         current program counter
//   halted     core is halted
//   retired    count of completed instructions (wraps)
module subleq_core #(
  parameter int                   WORD_SIZE = 8,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = {WORD_SIZE{1'b0}},
  parameter logic [WORD_SIZE-1:0] HALT_ADDR = {WORD_SIZE{1'b1}},
  parameter int                   CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 run,
  output logic                 load,
  output logic                 store,
  output logic [WORD_SIZE-1:0] addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_F_A  = 3'd0,
    S_F_B  = 3'd1,
    S_F_C  = 3'd2,
    S_R_A  = 3'd3,
    S_R_B  = 3'd4,
    S_WR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [WORD_SIZE-1:0] STEP_1 = WORD_SIZE'(2'd1);
  localparam logic [WORD_SIZE-1:0] STEP_2 = WORD_SIZE'(2'd2);
  localparam logic [WORD_SIZE-1:0] STEP_3 = WORD_SIZE'(2'd3);
  localparam logic [WORD_SIZE-1:0] ZERO_W = {WORD_SIZE{1'b0}};

  state_t                 state_r;
  state_t                 state_s;
  logic [WORD_SIZE-1:0]   pc_r;
  logic [WORD_SIZE-1:0]   ra_r;
  logic [WORD_SIZE-1:0]   rb_r;
  logic [WORD_SIZE-1:0]   rc_r;
  logic [WORD_SIZE-1:0]   va_r;
  logic [WORD_SIZE-1:0]   vb_r;
  logic [CNT_WIDTH-1:0]   retired_r;

  logic                   load_s;
  logic                   store_s;
  logic [WORD_SIZE-1:0]   addr_s;
  logic [WORD_SIZE-1:0]   wdata_s;
  logic [WORD_SIZE-1:0]   diff_s;
  logic                   taken_s;
  logic [WORD_SIZE-1:0]   pc_next_s;

  // Subtraction result, branch condition (negative or zero) and next pc.
  always_comb begin
    diff_s    = vb_r - va_r;
    taken_s   = diff_s[WORD_SIZE-1] | (diff_s == ZERO_W);
    pc_next_s = taken_s ? rc_r : (pc_r + STEP_3);
  end

  // Next-state and Moore memory-interface decode from the registered state.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    store_s = 1'b0;
    addr_s  = pc_r;
    wdata_s = ZERO_W;
    case (state_r)
      S_F_A: begin
        load_s = run;
        if (run) begin
          state_s = S_F_B;
        end else begin
          state_s = S_F_A;
        end
      end
      S_F_B: begin
        addr_s  = pc_r + STEP_1;
        load_s  = 1'b1;
        state_s = S_F_C;
      end
      S_F_C: begin
        addr_s  = pc_r + STEP_2;
        load_s  = 1'b1;
        state_s = S_R_A;
      end
      S_R_A: begin
        addr_s  = ra_r;
        load_s  = 1'b1;
        state_s = S_R_B;
      end
      S_R_B: begin
        addr_s  = rb_r;
        load_s  = 1'b1;
        state_s = S_WR;
      end
      S_WR: begin
        addr_s  = rb_r;
        store_s = 1'b1;
        wdata_s = diff_s;
        if (taken_s && (rc_r == HALT_ADDR)) begin
          state_s = S_HALT;
        end else begin
          state_s = S_F_A;
        end
      end
      S_HALT: begin
        state_s = S_HALT;
      end
      default: begin
        state_s = S_F_A;
      end
    endcase
  end

  // State, operand latches, pc and retired counter.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_r   <= S_F_A;
      pc_r      <= RESET_PC;
      ra_r      <= ZERO_W;
      rb_r      <= ZERO_W;
      rc_r      <= ZERO_W;
      va_r      <= ZERO_W;
      vb_r      <= ZERO_W;
      retired_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        S_F_A: begin
          if (run) begin
            ra_r <= mem_rdata;
          end else begin
            ra_r <= ra_r;
          end
        end
        S_F_B: rb_r <= mem_rdata;
        S_F_C: rc_r <= mem_rdata;
        S_R_A: va_r <= mem_rdata;
        S_R_B: vb_r <= mem_rdata;
        S_WR: begin
          pc_r      <= pc_next_s;
          retired_r <= retired_r + CNT_WIDTH'(1'b1);
        end
        default: begin
          pc_r <= pc_r;
        end
      endcase
    end
  end

  // A write pending at a reset edge must never reach memory.
  assign store     = store_s & ~areset;
  assign load      = load_s;
  assign addr      = addr_s;
  assign mem_wdata = wdata_s;
  assign pc        = pc_r;
  assign halted    = (state_r == S_HALT);
  assign retired   = retired_r;

endmodule

// File: tb/tb_subleq_core.sv
module tb_subleq_core;

  logic        clk;
  int          checks;
  int          failures;

  // Main instance (RESET_PC = 0)
  logic        areset;
  logic        run;
  logic        load;
  logic        store;
  logic [7:0]  addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] retired;
  logic [7:0]  mem [256];
  logic [7:0]  img [256];
  logic        img_copy;

  // Wrap instance (RESET_PC = 0xFE)
  logic        areset1;
  logic        run1;
  logic        load1;
  logic        store1;
  logic [7:0]  addr1;
  logic [7:0]  mem_wdata1;
  logic [7:0]  mem_rdata1;
  logic [7:0]  pc1;
  logic        halted1;
  logic [15:0] retired1;
  logic [7:0]  mem1 [256];
  logic [7:0]  img1 [256];
  logic        img_copy1;

  subleq_core #(.WORD_SIZE(8), .RESET_PC(8'h00), .HALT_ADDR(8'hFF), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .areset(areset), .run(run), .load(load), .store(store),
    .addr(addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pc(pc), .halted(halted), .retired(retired)
  );

  subleq_core #(.WORD_SIZE(8), .RESET_PC(8'hFE), .HALT_ADDR(8'hFF), .CNT_WIDTH(16)) u_dut_wrap (
    .clk(clk), .areset(areset1), .run(run1), .load(load1), .store(store1),
    .addr(addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .pc(pc1), .halted(halted1), .retired(retired1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: combinational read, write on rising edge, image preload.
  assign mem_rdata  = load  ? mem[addr]   : 8'h00;
  assign mem_rdata1 = load1 ? mem1[addr1] : 8'h00;

  always @(posedge clk) begin
    if (img_copy) mem <= img;
    else if (store) mem[addr] <= mem_wdata;
  end

  always @(posedge clk) begin
    if (img_copy1) mem1 <= img1;
    else if (store1) mem1[addr1] <= mem_wdata1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  // Hold reset over one edge while loading the memory image, then release.
  task automatic reset_load();
    areset   = 1'b1;
    img_copy = 1'b1;
    tick();
    img_copy = 1'b0;
    areset   = 1'b0;
  endtask

  task automatic basic_prog(input logic [7:0] c, input logic [7:0] va, input logic [7:0] vb);
    clear_img();
    img[0]     = 8'h10;
    img[1]     = 8'h11;
    img[2]     = c;
    img[8'h10] = va;
    img[8'h11] = vb;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    areset    = 1'b1;
    run       = 1'b1;
    img_copy  = 1'b0;
    areset1   = 1'b1;
    run1      = 1'b1;
    img_copy1 = 1'b0;
    for (int i = 0; i < 256; i++) img1[i] = 8'h00;
    #1;

    // Basic subtract: 5 - 3 = 2, not taken
    basic_prog(8'h20, 8'h03, 8'h05);
    reset_load();
    chk("rst_load",    load,      1);
    chk("rst_store",   store,     0);
    chk("rst_addr",    addr,      8'h00);
    chk("rst_wdata",   mem_wdata, 8'h00);
    chk("rst_pc",      pc,        8'h00);
    chk("rst_retired", retired,   0);
    chk("rst_halted",  halted,    0);
    tick();
    chk("fb_addr", addr, 8'h01);
    ticks(4);
    chk("wr_store", store,     1);
    chk("wr_load",  load,      0);
    chk("wr_addr",  addr,      8'h11);
    chk("wr_wdata", mem_wdata, 8'h02);
    tick();
    chk("basic_pc",      pc,        8'h03);
    chk("basic_retired", retired,   1);
    chk("basic_mem",     mem[8'h11], 8'h02);
    chk("basic_store0",  store,     0);

    // Branch on zero: 5 - 5 = 0
    basic_prog(8'h20, 8'h05, 8'h05);
    reset_load();
    ticks(6);
    chk("zero_mem", mem[8'h11], 8'h00);
    chk("zero_pc",  pc,         8'h20);

    // Branch on negative: 3 - 5 = 0xFE
    basic_prog(8'h20, 8'h05, 8'h03);
    reset_load();
    ticks(6);
    chk("neg_mem", mem[8'h11], 8'hFE);
    chk("neg_pc",  pc,         8'h20);
    chk("neg_halted", halted,  0);

    // Halt on taken branch to 0xFF
    basic_prog(8'hFF, 8'h05, 8'h05);
    reset_load();
    ticks(6);
    chk("halt_halted",  halted,  1);
    chk("halt_pc",      pc,      8'hFF);
    chk("halt_retired", retired, 1);
    for (int i = 0; i < 20; i++) begin
      chk("halt_load",  load,  0);
      chk("halt_store", store, 0);
      tick();
    end
    chk("halt_addr",     addr,    8'hFF);
    chk("halt_retired2", retired, 1);

    // Address wrap on the RESET_PC=0xFE instance
    img1[8'hFE] = 8'h10;
    img1[8'hFF] = 8'h11;
    img1[8'h00] = 8'h20;
    img1[8'h10] = 8'h03;
    img1[8'h11] = 8'h05;
    areset1   = 1'b1;
    img_copy1 = 1'b1;
    tick();
    img_copy1 = 1'b0;
    areset1   = 1'b0;
    chk("wrap_fa", addr1, 8'hFE);
    tick();
    chk("wrap_fb", addr1, 8'hFF);
    tick();
    chk("wrap_fc", addr1, 8'h00);
    ticks(4);
    chk("wrap_pc",     pc1,         8'h01);
    chk("wrap_halted", halted1,     0);
    chk("wrap_mem",    mem1[8'h11], 8'h02);
    chk("wrap_retired", retired1,   1);

    // Run gating
    basic_prog(8'h20, 8'h03, 8'h05);
    run = 1'b0;
    reset_load();
    for (int i = 0; i < 10; i++) begin
      chk("gate_load", load, 0);
      chk("gate_addr", addr, 8'h00);
      tick();
    end
    chk("gate_retired0", retired, 0);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("gate_fb_addr", addr, 8'h01);
    ticks(5);
    chk("gate_retired1", retired, 1);
    chk("gate_pc",       pc,      8'h03);
    ticks(5);
    chk("gate_retired_hold", retired, 1);
    chk("gate_stall_load",   load,    0);
    chk("gate_stall_addr",   addr,    8'h03);

    // Reset during WR suppresses the store
    run = 1'b1;
    basic_prog(8'h20, 8'h03, 8'h05);
    reset_load();
    ticks(5);
    chk("mid_pre_store", store, 1);
    areset = 1'b1;
    #1;
    chk("mid_store_suppressed", store, 0);
    tick();
    areset = 1'b0;
    chk("mid_mem",     mem[8'h11], 8'h05);
    chk("mid_pc",      pc,         8'h00);
    chk("mid_retired", retired,    0);
    chk("mid_addr",    addr,       8'h00);
    ticks(6);
    chk("mid_restart_mem",     mem[8'h11], 8'h02);
    chk("mid_restart_retired", retired,    1);
    chk("mid_restart_pc",      pc,         8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
